// File: rtl/spn_iter_core_if.sv
// Command and result channels of the iterative SPN core.
// in_valid/in_ready and out_valid/out_ready are valid/ready pairs: a beat transfers on a rising edge where both are high.
interface spn_iter_core_if #(
   parameter int BLOCK_W = 16,
   parameter int KEY_W   = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         opcode;
   logic [BLOCK_W-1:0] data_in;
   logic [KEY_W-1:0]   symmetric_secret_key;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] data_out;
   logic [1:0]         out_op;
   logic               err;

   modport master (
      output in_valid, opcode, data_in, symmetric_secret_key, out_ready,
      input  in_ready, out_valid, data_out, out_op, err
   );

   modport slave (
      input  in_valid, opcode, data_in, symmetric_secret_key, out_ready,
      output in_ready, out_valid, data_out, out_op, err
   );
endinterface

// File: rtl/spn_iter_core.sv
// Iterative SPN encrypt/decrypt core: one round per clock through a shared datapath.
// Includes the nibble S-box package used by the round function.
package spn_sbox_pkg;
   localparam logic [3:0] SBOX_TBL [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };
   localparam logic [3:0] SBOX_INV_TBL [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TBL[x];
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      return SBOX_INV_TBL[x];
   endfunction
endpackage

module spn_iter_core
   import spn_sbox_pkg::*;
#(
   parameter int BLOCK_W    = 16,
   parameter int KEY_W      = 32,
   parameter int NUM_ROUNDS = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   spn_iter_core_if.slave bus,
   output logic [1:0]     o_dbg_state
);
   localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t             r_fsm, w_fsm_nxt;
   logic [BLOCK_W-1:0] r_state, r_data_out;
   logic [KEY_W-1:0]   r_key;
   logic [1:0]         r_op, r_out_op;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_valid, r_err;
   logic               w_legal, w_accept, w_illegal, w_last, w_release;
   int                 w_rk_sel;
   logic [BLOCK_W-1:0] w_enc_nxt, w_dec_nxt, w_round_nxt, w_result, w_load;

   function automatic logic [BLOCK_W-1:0] sub(input logic [BLOCK_W-1:0] x);
      logic [BLOCK_W-1:0] y;
      for (int n = 0; n < BLOCK_W/4; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
      return y;
   endfunction

   function automatic logic [BLOCK_W-1:0] sub_inv(input logic [BLOCK_W-1:0] x);
      logic [BLOCK_W-1:0] y;
      for (int n = 0; n < BLOCK_W/4; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
      return y;
   endfunction

   // The top bit never moves; every other bit i lands on (i*BLOCK_W/4) mod (BLOCK_W-1).
   function automatic logic [BLOCK_W-1:0] perm(input logic [BLOCK_W-1:0] x);
      logic [BLOCK_W-1:0] y;
      y = x;
      for (int i = 0; i < BLOCK_W-1; i++) y[(i*(BLOCK_W/4)) % (BLOCK_W-1)] = x[i];
      return y;
   endfunction

   function automatic logic [BLOCK_W-1:0] perm_inv(input logic [BLOCK_W-1:0] x);
      logic [BLOCK_W-1:0] y;
      y = x;
      for (int i = 0; i < BLOCK_W-1; i++) y[i] = x[(i*(BLOCK_W/4)) % (BLOCK_W-1)];
      return y;
   endfunction

   // Low BLOCK_W bits of the key rotated left by 8*r.
   function automatic logic [BLOCK_W-1:0] round_key(input logic [KEY_W-1:0] key, input int r);
      logic [2*KEY_W-1:0] dbl;
      int                 amt;
      amt = (8 * r) % KEY_W;
      dbl = {key, key} >> (KEY_W - amt);
      return dbl[BLOCK_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fsm <= S_IDLE;
      else        r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_legal   = (bus.opcode == 2'b01) || (bus.opcode == 2'b10);
      w_accept  = (r_fsm == S_IDLE) && bus.in_valid && w_legal;
      w_illegal = (r_fsm == S_IDLE) && bus.in_valid && !w_legal;
      w_last    = (r_cnt == CNT_W'(NUM_ROUNDS - 1));
      w_release = (r_fsm == S_DONE) && bus.out_ready;
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         S_IDLE:  if (w_accept) w_fsm_nxt = S_RUN;
         S_RUN:   if (w_last) w_fsm_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_fsm_nxt = S_IDLE;
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   // Decrypt walks the rounds backwards; its first round (counter 0) skips the inverse permutation.
   always_comb begin
      w_rk_sel  = (r_op == 2'b01) ? int'(r_cnt) : NUM_ROUNDS - 1 - int'(r_cnt);
      w_enc_nxt = sub(r_state ^ round_key(r_key, w_rk_sel));
      if (!w_last) w_enc_nxt = perm(w_enc_nxt);
      w_dec_nxt = (r_cnt == '0) ? r_state : perm_inv(r_state);
      w_dec_nxt = sub_inv(w_dec_nxt) ^ round_key(r_key, w_rk_sel);
      w_round_nxt = (r_op == 2'b01) ? w_enc_nxt : w_dec_nxt;
      w_result    = (r_op == 2'b01) ? (w_enc_nxt ^ round_key(r_key, NUM_ROUNDS)) : w_dec_nxt;
      w_load      = (bus.opcode == 2'b10)
                  ? (bus.data_in ^ round_key(bus.symmetric_secret_key, NUM_ROUNDS))
                  : bus.data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= '0;
         r_key       <= '0;
         r_op        <= 2'b00;
         r_cnt       <= '0;
         r_data_out  <= '0;
         r_out_op    <= 2'b00;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_illegal;
         if (w_accept) begin
            r_op    <= bus.opcode;
            r_key   <= bus.symmetric_secret_key;
            r_state <= w_load;
            r_cnt   <= '0;
         end else if (r_fsm == S_RUN) begin
            r_state <= w_round_nxt;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               r_data_out  <= w_result;
               r_out_op    <= r_op;
               r_out_valid <= 1'b1;
            end
         end else if (w_release) begin
            r_out_valid <= 1'b0;
            r_out_op    <= 2'b00;
         end
      end
   end

   assign bus.in_ready  = (r_fsm == S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_data_out;
   assign bus.out_op    = r_out_op;
   assign bus.err       = r_err;
   assign o_dbg_state   = r_fsm;
endmodule

// File: tb/tb_spn_iter_core.sv
// Bench for spn_iter_core: directed handshake/reset/error steps on the default core,
// random encrypt/decrypt round trips on two wider cores, all against a bit-level model.
module tb_spn_iter_core;
   import spn_sbox_pkg::*;

   logic clk;
   logic rst_n;
   logic [1:0] dbg_a, dbg_b, dbg_c;

   spn_iter_core_if #(.BLOCK_W(16), .KEY_W(32)) ifa ();
   spn_iter_core_if #(.BLOCK_W(32), .KEY_W(64)) ifb ();
   spn_iter_core_if #(.BLOCK_W(32), .KEY_W(64)) ifc ();

   spn_iter_core #(.BLOCK_W(16), .KEY_W(32), .NUM_ROUNDS(3)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa), .o_dbg_state(dbg_a));
   spn_iter_core #(.BLOCK_W(32), .KEY_W(64), .NUM_ROUNDS(7)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb), .o_dbg_state(dbg_b));
   spn_iter_core #(.BLOCK_W(32), .KEY_W(64), .NUM_ROUNDS(1)) u_c (
      .clk(clk), .rst_n(rst_n), .bus(ifc), .o_dbg_state(dbg_c));

   int n_pass = 0;
   int n_total = 0;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [63:0] msk(input int w);
      return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] m_rk(input logic [63:0] k, input int kw, input int w, input int r);
      logic [63:0] kk;
      int amt;
      amt = (8 * r) % kw;
      kk  = k & msk(kw);
      kk  = ((kk << amt) | (kk >> (kw - amt))) & msk(kw);
      return kk & msk(w);
   endfunction

   function automatic logic [63:0] m_sub(input logic [63:0] x, input int w, input bit inv);
      logic [63:0] y;
      logic [3:0] nib;
      y = x;
      for (int n = 0; n < w/4; n++) begin
         nib = x[4*n +: 4];
         if (!inv) y[4*n +: 4] = sbox(nib);
         else begin
            for (int j = 0; j < 16; j++)
               if (sbox(4'(j)) == nib) y[4*n +: 4] = 4'(j);
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] m_perm(input logic [63:0] x, input int w, input bit inv);
      logic [63:0] y;
      int dest;
      y = x;
      for (int i = 0; i < w-1; i++) begin
         dest = (i * (w/4)) % (w-1);
         if (!inv) y[dest] = x[i];
         else      y[i]    = x[dest];
      end
      return y;
   endfunction

   function automatic logic [63:0] m_enc(input int w, input int kw, input int nr,
                                         input logic [63:0] x, input logic [63:0] k);
      logic [63:0] s;
      s = x & msk(w);
      for (int r = 0; r < nr; r++) begin
         s = m_sub(s ^ m_rk(k, kw, w, r), w, 1'b0);
         if (r != nr-1) s = m_perm(s, w, 1'b0);
      end
      return s ^ m_rk(k, kw, w, nr);
   endfunction

   function automatic logic [63:0] m_dec(input int w, input int kw, input int nr,
                                         input logic [63:0] c, input logic [63:0] k);
      logic [63:0] s;
      s = (c & msk(w)) ^ m_rk(k, kw, w, nr);
      for (int r = nr-1; r >= 0; r--) begin
         if (r != nr-1) s = m_perm(s, w, 1'b1);
         s = m_sub(s, w, 1'b1) ^ m_rk(k, kw, w, r);
      end
      return s;
   endfunction

   // ---------------- driver / sampling helpers ----------------
   task automatic set_in(input int inst, input logic v, input logic [1:0] op,
                         input logic [63:0] d, input logic [63:0] k);
      case (inst)
         0: begin ifa.in_valid = v; ifa.opcode = op; ifa.data_in = d[15:0]; ifa.symmetric_secret_key = k[31:0]; end
         1: begin ifb.in_valid = v; ifb.opcode = op; ifb.data_in = d[31:0]; ifb.symmetric_secret_key = k; end
         default: begin ifc.in_valid = v; ifc.opcode = op; ifc.data_in = d[31:0]; ifc.symmetric_secret_key = k; end
      endcase
   endtask

   task automatic set_ordy(input int inst, input logic v);
      case (inst)
         0: ifa.out_ready = v;
         1: ifb.out_ready = v;
         default: ifc.out_ready = v;
      endcase
   endtask

   function automatic logic [63:0] get_ready(input int inst);
      return (inst == 0) ? 64'(ifa.in_ready) : (inst == 1) ? 64'(ifb.in_ready) : 64'(ifc.in_ready);
   endfunction
   function automatic logic [63:0] get_valid(input int inst);
      return (inst == 0) ? 64'(ifa.out_valid) : (inst == 1) ? 64'(ifb.out_valid) : 64'(ifc.out_valid);
   endfunction
   function automatic logic [63:0] get_data(input int inst);
      return (inst == 0) ? 64'(ifa.data_out) : (inst == 1) ? 64'(ifb.data_out) : 64'(ifc.data_out);
   endfunction
   function automatic logic [63:0] get_op(input int inst);
      return (inst == 0) ? 64'(ifa.out_op) : (inst == 1) ? 64'(ifb.out_op) : 64'(ifc.out_op);
   endfunction
   function automatic logic [63:0] get_err(input int inst);
      return (inst == 0) ? 64'(ifa.err) : (inst == 1) ? 64'(ifb.err) : 64'(ifc.err);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input int inst, input string tag);
      check({tag, "_in_ready"},  get_ready(inst), 64'd1);
      check({tag, "_out_valid"}, get_valid(inst), 64'd0);
      check({tag, "_data_out"},  get_data(inst),  64'd0);
      check({tag, "_out_op"},    get_op(inst),    64'd0);
      check({tag, "_err"},       get_err(inst),   64'd0);
   endtask

   // One command with out_ready held high; the key input is scrambled every cycle after accept.
   task automatic run_op(input int inst, input logic [1:0] op, input logic [63:0] d,
                         input logic [63:0] k, output logic [63:0] res,
                         output logic [63:0] rop, output int lat);
      @(negedge clk);
      check("pre_in_ready", get_ready(inst), 64'd1);
      set_in(inst, 1'b1, op, d, k);
      @(negedge clk);
      set_in(inst, 1'b0, 2'b00, 64'd0, {$urandom, $urandom});
      lat = 0;
      while (get_valid(inst) != 64'd1 && lat < 40) begin
         @(negedge clk);
         lat++;
         set_in(inst, 1'b0, 2'b00, 64'd0, {$urandom, $urandom});
      end
      res = get_data(inst);
      rop = get_op(inst);
      @(negedge clk);
      check("consumed_valid", get_valid(inst), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [63:0] res, res2, rop, held_d, exp_c, d, k;
   int lat;

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(i, 1'b0, 2'b00, 64'd0, 64'd0);
         set_ordy(i, 1'b1);
      end
      repeat (3) @(negedge clk);
      check_reset_outputs(0, "rst_a");
      check_reset_outputs(1, "rst_b");
      rst_n = 1'b1;

      // round trip on the default core
      exp_c = m_enc(16, 32, 3, 64'h1234, 64'hA5A5_5A5A);
      run_op(0, 2'b01, 64'h1234, 64'hA5A5_5A5A, res, rop, lat);
      check("rt_enc_data", res, exp_c);
      check("rt_enc_op", rop, 64'd1);
      check("rt_enc_lat", 64'(lat), 64'd3);
      run_op(0, 2'b10, res, 64'hA5A5_5A5A, res2, rop, lat);
      check("rt_dec_data", res2, 64'h1234);
      check("rt_dec_model", res2, m_dec(16, 32, 3, res, 64'hA5A5_5A5A));
      check("rt_dec_op", rop, 64'd2);
      check("rt_dec_lat", 64'(lat), 64'd3);

      // backpressure with ignored commands while the result is held
      set_ordy(0, 1'b0);
      d = 64'($urandom_range(0, 16'hFFFF));
      k = 64'($urandom);
      exp_c = m_enc(16, 32, 3, d, k);
      @(negedge clk);
      set_in(0, 1'b1, 2'b01, d, k);
      @(negedge clk);
      set_in(0, 1'b0, 2'b00, 64'd0, 64'd0);
      lat = 0;
      while (get_valid(0) != 64'd1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("bp_lat", 64'(lat), 64'd3);
      check("bp_data", get_data(0), exp_c);
      held_d = exp_c;
      for (int c = 0; c < 10; c++) begin
         set_in(0, c[0], 2'b01 + 2'(c[1]), 64'($urandom), 64'($urandom));
         @(negedge clk);
         check("bp_hold_data", get_data(0), held_d);
         check("bp_hold_op", get_op(0), 64'd1);
         check("bp_hold_valid", get_valid(0), 64'd1);
         check("bp_in_ready", get_ready(0), 64'd0);
      end
      set_in(0, 1'b0, 2'b00, 64'd0, 64'd0);
      set_ordy(0, 1'b1);
      @(negedge clk);
      check("bp_rel_valid", get_valid(0), 64'd0);
      check("bp_rel_op", get_op(0), 64'd0);
      check("bp_rel_ready", get_ready(0), 64'd1);
      check("bp_rel_data", get_data(0), held_d);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_no_extra", get_valid(0), 64'd0);
      end

      // illegal opcodes
      for (int j = 0; j < 2; j++) begin
         set_in(0, 1'b1, (j == 0) ? 2'b00 : 2'b11, 64'h55AA, 64'h1);
         @(negedge clk);
         set_in(0, 1'b0, 2'b00, 64'd0, 64'd0);
         check("ill_err_hi", get_err(0), 64'd1);
         check("ill_in_ready", get_ready(0), 64'd1);
         check("ill_no_valid", get_valid(0), 64'd0);
         @(negedge clk);
         check("ill_err_lo", get_err(0), 64'd0);
         check("ill_no_valid2", get_valid(0), 64'd0);
      end

      // reset asserted mid-RUN
      set_in(0, 1'b1, 2'b01, 64'hBEEF, 64'hCAFE_F00D);
      @(negedge clk);
      set_in(0, 1'b0, 2'b00, 64'd0, 64'd0);
      @(negedge clk);
      check("mid_run_ready", get_ready(0), 64'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(0, "async_rst");
      @(negedge clk);
      check_reset_outputs(0, "held_rst");
      rst_n = 1'b1;
      exp_c = m_enc(16, 32, 3, 64'h0F0F, 64'h1357_9BDF);
      run_op(0, 2'b01, 64'h0F0F, 64'h1357_9BDF, res, rop, lat);
      check("post_rst_data", res, exp_c);
      check("post_rst_lat", 64'(lat), 64'd3);

      // random sweep on the wide cores
      for (int inst = 1; inst <= 2; inst++) begin
         int nr;
         nr = (inst == 1) ? 7 : 1;
         for (int n = 0; n < 1000; n++) begin
            d = {32'd0, $urandom};
            k = {$urandom, $urandom};
            exp_c = m_enc(32, 64, nr, d, k);
            run_op(inst, 2'b01, d, k, res, rop, lat);
            check("sw_enc_data", res, exp_c);
            check("sw_enc_op", rop, 64'd1);
            check("sw_enc_lat", 64'(lat), 64'(nr));
            run_op(inst, 2'b10, res, k, res2, rop, lat);
            check("sw_dec_data", res2, d);
            check("sw_dec_op", rop, 64'd2);
            check("sw_dec_lat", 64'(lat), 64'(nr));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
